game_stats_tracker: RTL and testbench
=====================================

GAME_STATS_TRACKER -- requirements
Module: game_stats_tracker

Interface
REQ-001 SHALL have parameter TICK_DIV, default 650000, meaning pclk cycles per 1/100 s tick (65 MHz pixel clock).
REQ-002 SHALL have parameter NUM_W, default `CARD_MAX_NUM_SIZE, meaning width of num_of_cards.
REQ-003 SHALL use one clock; reset is synchronous and active-low; ports named pclk and rst.
REQ-004 pclk  input  1  pixel clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 start_game  input  1  one-cycle pulse; starts a new game.
REQ-007 num_of_cards  input  NUM_W  cards on board; sampled on start_game; even, 2..2^NUM_W-2.
REQ-008 pair_found  input  1  one-cycle pulse; a matched pair was discovered.
REQ-009 pause  input  1  level; freezes the game clock while high.
REQ-010 discovered_pairs_ctr  output  8  pairs found in the current game.
REQ-011 game_time  output  13  {seconds[5:0], hundredths[6:0]}; hundredths 0..99, seconds 0..63.
REQ-012 game_over_en  output  1  level; high from game end until next start_game or reset.
REQ-013 running  output  1  level; high in RUNNING.

Function
REQ-014 SHALL implement states IDLE, RUNNING, FINISHED; reset state IDLE.
REQ-015 Any state + start_game SHALL go to RUNNING next cycle; clear pairs counter, game_time, prescaler; latch target = num_of_cards>>1.
REQ-016 start_game SHALL take priority over pair_found, tick and pause in the same cycle; that pair_found is dropped.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only in RUNNING with pause low; tick = one-cycle strobe at count TICK_DIV-1, then wrap to 0.
REQ-018 While pause high, prescaler and game_time SHALL hold; counting resumes from the held prescaler value.
REQ-019 On tick: hundredths+1; at 99 hundredths wraps to 0, seconds+1.
REQ-020 At 63.99 game_time SHALL saturate (no wrap); game stays RUNNING.
REQ-021 pair_found in RUNNING SHALL increment discovered_pairs_ctr by 1, visible next cycle; ignored in IDLE and FINISHED; counter saturates at 255.
REQ-022 When pair_found takes the counter to target, SHALL go to FINISHED next cycle; game_over_en and counter update in that same cycle.
REQ-023 A tick in the cycle of the final pair_found SHALL be counted; no later tick counted.
REQ-024 In FINISHED, discovered_pairs_ctr and game_time SHALL hold for the endgame screen.
REQ-025 pause SHALL NOT block pair_found counting.
REQ-026 target 0 (num_of_cards<2) SHALL be treated as 1.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst low at a pclk edge SHALL force IDLE, discovered_pairs_ctr=0, game_time=0, game_over_en=0, running=0, prescaler=0, target=0, any state.
REQ-029 Reset mid-game SHALL discard progress; start_game in the reset-release cycle is ignored.
REQ-030 In IDLE after reset, outputs SHALL stay 0 until start_game.

Verification (TICK_DIV=4)
REQ-031 Reset, start_game, num_of_cards=4, run 400 cycles -> game_time=13'd128 (1.00 s), running=1, pairs=0.
REQ-032 Start num_of_cards=4, pair_found at cycles 10 and 20 -> pairs=2, game_over_en=1 at cycle 21, game_time frozen at 0.05.
REQ-033 Pause high 100 cycles mid-game -> game_time unchanged during pause; +1 hundredth 4 cycles after release.
REQ-034 Run 25700 cycles without pairs -> game_time={6'd63,7'd99}, holds, running=1.
REQ-035 start_game and pair_found same cycle, from FINISHED -> pairs=0, game_over_en=0, running=1 next cycle.
REQ-036 rst low in RUNNING with pairs=3 -> all outputs 0 next cycle; pair_found in IDLE leaves pairs=0.

Source files
------------

// File: rtl/game_stats_tracker.sv
// Memory-game statistics: pair counter, 1/100 s game clock and game state for the endgame screen.
// All outputs registered; state/counters update on the pclk edge after the input pulse.
`ifndef CARD_MAX_NUM_SIZE
`define CARD_MAX_NUM_SIZE 8
`endif

module game_stats_tracker #(
    parameter int TICK_DIV = 650000,
    parameter int NUM_W    = `CARD_MAX_NUM_SIZE
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             start_game,
    input  logic [NUM_W-1:0] num_of_cards,
    input  logic             pair_found,
    input  logic             pause,
    output logic [7:0]       discovered_pairs_ctr,
    output logic [12:0]      game_time,
    output logic             game_over_en,
    output logic             running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    // Common width so a target wider than the 8-bit counter still compares correctly.
    localparam int CW = (NUM_W > 8) ? NUM_W : 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [6:0]       hund_q, hund_d;
    logic [5:0]       sec_q, sec_d;
    logic [7:0]       pairs_q, pairs_d;
    logic [NUM_W-1:0] target_q, target_d;
    logic             game_over_q, game_over_d;
    logic             running_q, running_d;
    logic             tick;
    logic [NUM_W-1:0] half_cards;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        hund_d     = hund_q;
        sec_d      = sec_q;
        pairs_d    = pairs_q;
        target_d   = target_q;
        tick       = 1'b0;
        half_cards = num_of_cards >> 1;

        if (start_game) begin
            state_d  = RUNNING;
            presc_d  = '0;
            hund_d   = '0;
            sec_d    = '0;
            pairs_d  = '0;
            target_d = (half_cards == '0) ? NUM_W'(1) : half_cards;
        end else begin
            case (state_q)
                RUNNING: begin
                    if (!pause) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            tick    = 1'b1;
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                    // Clock stops at 63.99 rather than wrapping to 0.00.
                    if (tick && !(sec_q == 6'd63 && hund_q == 7'd99)) begin
                        if (hund_q == 7'd99) begin
                            hund_d = 7'd0;
                            sec_d  = sec_q + 6'd1;
                        end else begin
                            hund_d = hund_q + 7'd1;
                        end
                    end
                    if (pair_found) begin
                        if (pairs_q != 8'hFF) begin
                            pairs_d = pairs_q + 8'd1;
                        end
                        if (CW'(pairs_d) == CW'(target_q)) begin
                            state_d = FINISHED;
                        end
                    end
                end
                default: ;
            endcase
        end

        game_over_d = (state_d == FINISHED);
        running_d   = (state_d == RUNNING);
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            hund_q      <= '0;
            sec_q       <= '0;
            pairs_q     <= '0;
            target_q    <= '0;
            game_over_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hund_q      <= hund_d;
            sec_q       <= sec_d;
            pairs_q     <= pairs_d;
            target_q    <= target_d;
            game_over_q <= game_over_d;
            running_q   <= running_d;
        end
    end

    assign discovered_pairs_ctr = pairs_q;
    assign game_time            = {sec_q, hund_q};
    assign game_over_en         = game_over_q;
    assign running              = running_q;

endmodule

// File: tb/tb_game_stats_tracker.sv
// Bench for game_stats_tracker: directed vector table, then random traffic against a reference model.
module tb_game_stats_tracker;

    localparam int TDIV = 4;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_game = 1'b0;
    logic [7:0]  num_of_cards = 8'd0;
    logic        pair_found = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  discovered_pairs_ctr;
    logic [12:0] game_time;
    logic        game_over_en;
    logic        running;

    int checks = 0;
    int errors = 0;

    game_stats_tracker #(.TICK_DIV(TDIV), .NUM_W(8)) dut (
        .pclk                 (pclk),
        .rst                  (rst_n),
        .start_game           (start_game),
        .num_of_cards         (num_of_cards),
        .pair_found           (pair_found),
        .pause                (pause),
        .discovered_pairs_ctr (discovered_pairs_ctr),
        .game_time            (game_time),
        .game_over_en         (game_over_en),
        .running              (running)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [7:0]  num;
        logic        pair;
        logic        pause;
        int          rep;
        logic [7:0]  e_pairs;
        logic [12:0] e_time;
        logic        e_over;
        logic        e_run;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic [7:0] n, logic p, logic ps, int rep,
                                logic [7:0] ep, logic [12:0] et, logic eo, logic er);
        vec_t v;
        v.rst_n = r; v.start = s; v.num = n; v.pair = p; v.pause = ps; v.rep = rep;
        v.e_pairs = ep; v.e_time = et; v.e_over = eo; v.e_run = er;
        return v;
    endfunction

    task automatic compare(input string name, input int idx, input logic [7:0] ep,
                           input logic [12:0] et, input logic eo, input logic er);
        checks++;
        if (discovered_pairs_ctr !== ep || game_time !== et || game_over_en !== eo || running !== er) begin
            errors++;
            $display("FAIL %s #%0d: got pairs=%0d time=%0d.%0d over=%b run=%b, want pairs=%0d time=%0d.%0d over=%b run=%b",
                     name, idx, discovered_pairs_ctr, game_time[12:7], game_time[6:0], game_over_en, running,
                     ep, et[12:7], et[6:0], eo, er);
        end
    endtask

    // Reference model: whole-game view in plain integers (total hundredths, pair count).
    bit m_run, m_over;
    int m_pairs, m_target, m_hundredths, m_phase;

    task automatic model_step(input logic r, input logic s, input logic [7:0] n,
                              input logic p, input logic ps);
        if (!r) begin
            m_run = 0; m_over = 0; m_pairs = 0; m_target = 0; m_hundredths = 0; m_phase = 0;
        end else if (s) begin
            m_run = 1; m_over = 0; m_pairs = 0; m_hundredths = 0; m_phase = 0;
            m_target = (int'(n) / 2 == 0) ? 1 : int'(n) / 2;
        end else if (m_run) begin
            if (!ps) begin
                m_phase++;
                if (m_phase == TDIV) begin
                    m_phase = 0;
                    if (m_hundredths < 6399) m_hundredths++;
                end
            end
            if (p) begin
                if (m_pairs < 255) m_pairs++;
                if (m_pairs == m_target) begin
                    m_run = 0;
                    m_over = 1;
                end
            end
        end
    endtask

    function automatic logic [12:0] to_time(int h);
        logic [5:0] s;
        logic [6:0] c;
        s = 6'(h / 100);
        c = 7'(h % 100);
        return {s, c};
    endfunction

    initial begin
        tbl.push_back(mk(0,0,  0,0,0,    3, 0,   0,0,0));
        tbl.push_back(mk(1,0,  0,0,0,    5, 0,   0,0,0));
        tbl.push_back(mk(1,0,  0,1,0,    1, 0,   0,0,0));
        tbl.push_back(mk(1,1,  4,0,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0,  4,0,0,  400, 0, 128,0,1));
        tbl.push_back(mk(1,1,  4,0,0,   10, 0,   2,0,1));
        tbl.push_back(mk(1,0,  4,1,0,   10, 1,   4,0,1));
        tbl.push_back(mk(1,0,  4,1,0,    1, 2,   5,1,0));
        tbl.push_back(mk(1,0,  4,0,0,   20, 2,   5,1,0));
        tbl.push_back(mk(1,0,  4,1,0,    1, 2,   5,1,0));
        tbl.push_back(mk(1,1,  6,1,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0,  6,0,0,    4, 0,   1,0,1));
        tbl.push_back(mk(1,0,  6,0,1,  100, 0,   1,0,1));
        tbl.push_back(mk(1,0,  6,0,0,    3, 0,   1,0,1));
        tbl.push_back(mk(1,0,  6,0,0,    1, 0,   2,0,1));
        tbl.push_back(mk(1,0,  6,1,1,    1, 1,   2,0,1));
        tbl.push_back(mk(1,1, 10,0,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0, 10,1,0,    1, 1,   0,0,1));
        tbl.push_back(mk(1,0, 10,1,0,    1, 2,   0,0,1));
        tbl.push_back(mk(1,0, 10,1,0,    1, 3,   0,0,1));
        tbl.push_back(mk(0,1, 10,1,0,    1, 0,   0,0,0));
        tbl.push_back(mk(1,0, 10,1,0,    1, 0,   0,0,0));
        tbl.push_back(mk(1,1,  0,0,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0,  0,1,0,    1, 1,   0,1,0));
        tbl.push_back(mk(1,1,  1,0,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0,  1,1,0,    1, 1,   0,1,0));
        tbl.push_back(mk(1,1,  4,0,0,    1, 0,   0,0,1));
        tbl.push_back(mk(1,0,  4,0,0,25595, 0, 8162,0,1));
        tbl.push_back(mk(1,0,  4,0,0,    1, 0, 8163,0,1));
        tbl.push_back(mk(1,0,  4,0,0,  105, 0, 8163,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n        = tbl[i].rst_n;
            start_game   = tbl[i].start;
            num_of_cards = tbl[i].num;
            pair_found   = tbl[i].pair;
            pause        = tbl[i].pause;
            @(posedge pclk);
            #1;
            start_game = 1'b0;
            pair_found = 1'b0;
            for (int k = 1; k < tbl[i].rep; k++) begin
                @(posedge pclk);
                #1;
            end
            compare("vector", i, tbl[i].e_pairs, tbl[i].e_time, tbl[i].e_over, tbl[i].e_run);
        end

        rst_n = 1'b0; start_game = 1'b0; pair_found = 1'b0; pause = 1'b0;
        model_step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge pclk);
        #1;
        compare("rand_reset", 0, 8'(m_pairs), to_time(m_hundredths), m_over, m_run);

        for (int c = 0; c < 4000; c++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            start_game   = ($urandom_range(0, 59) == 0);
            num_of_cards = ($urandom_range(0, 19) == 0) ? 8'd254 : 8'($urandom_range(0, 14));
            pair_found   = ($urandom_range(0, 5) == 0);
            pause        = ($urandom_range(0, 4) == 0);
            model_step(rst_n, start_game, num_of_cards, pair_found, pause);
            @(posedge pclk);
            #1;
            compare("random", c, 8'(m_pairs), to_time(m_hundredths), m_over, m_run);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
